// File: rtl/pwm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pwm_ctrl_pkg
// Shared types and default constants for the pwm button conditioner.
//   db_state_e      : per-channel debounce FSM state (2-bit, 0..3)
//   DEF_*           : default parameter values used by the conditioner
// ----------------------------------------------------------------------------
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_REPEAT_DELAY    = 512;
    localparam int unsigned DEF_REPEAT_PERIOD   = 64;

endpackage

// File: rtl/debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// One button lane: synchroniser chain, debounce FSM and (with AUTOREPEAT_EN
// defined) an auto-repeat counter that runs while the button is held.
//
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   btn_raw  : raw asynchronous button level, active-high
//   evt      : one-cycle event strobe (press or repeat), combinational from
//              registered state; the top level registers it
//   held     : debounced button level (HELD or RELEASE_WAIT)
//
// Build option: AUTOREPEAT_EN enables the repeat counter.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | button released and stable
// PRESS_WAIT   | synchronised level high, counting toward acceptance
// HELD         | press accepted, button still down
// RELEASE_WAIT | synchronised level low, counting toward release
// ----------------------------------------------------------------------------
module debounce_channel
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic evt,
    output logic held
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_e              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   press_evt;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // The terminal-count compare doubles as saturation: the counter is never
    // incremented once it reaches CNT_LAST because the FSM leaves that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HELD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_q <= HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign press_evt = (state_q == PRESS_WAIT) && s && (cnt_q == CNT_LAST);
    assign held      = (state_q == HELD) || (state_q == RELEASE_WAIT);

`ifdef AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_armed_q;   // first (long) delay already elapsed
    logic             rpt_hit;
    logic             rpt_evt;

    assign rpt_hit = (rpt_cnt_q == (rpt_armed_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST));
    assign rpt_evt = (state_q == HELD) && s && rpt_hit;

    // Counts only on HELD cycles that stay in HELD; frozen in RELEASE_WAIT
    // so a release bounce resumes where it left off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else if (state_q == IDLE) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else if ((state_q == HELD) && s) begin
            if (rpt_hit) begin
                rpt_cnt_q   <= '0;
                rpt_armed_q <= 1'b1;
            end else begin
                rpt_cnt_q <= rpt_cnt_q + 1'b1;
            end
        end
    end

    assign evt = press_evt | rpt_evt;
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign evt = press_evt;
`endif

endmodule

// File: rtl/pwm_button_conditioner.sv
// ----------------------------------------------------------------------------
// pwm_button_conditioner
// Conditions the raw up/down push buttons for the pwm duty-cycle block.
// Each button is synchronised and debounced; every accepted press yields a
// single registered pulse on increase_duty_sync / decrease_duty_sync.
//
// Ports:
//   clk                : system clock, rising edge
//   rst_n              : asynchronous active-low reset
//   btn_up_raw         : raw "increase" button, asynchronous, active-high
//   btn_dn_raw         : raw "decrease" button, asynchronous, active-high
//   increase_duty_sync : one-cycle pulse per accepted up event
//   decrease_duty_sync : one-cycle pulse per accepted down event
//   up_held            : debounced up level
//   dn_held            : debounced down level
//
// Build option: AUTOREPEAT_EN adds auto-repeat pulses while a button is held.
// ----------------------------------------------------------------------------
module pwm_button_conditioner
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up_raw,
    input  logic btn_dn_raw,
    output logic increase_duty_sync,
    output logic decrease_duty_sync,
    output logic up_held,
    output logic dn_held
);

    logic up_evt;
    logic dn_evt;
    logic inc_q, inc_d;
    logic dec_q, dec_d;

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_up (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_up_raw),
        .evt    (up_evt),
        .held   (up_held)
    );

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_dn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_dn_raw),
        .evt    (dn_evt),
        .held   (dn_held)
    );

    // Coincident events cancel each other. Masking with the current output
    // guarantees a low cycle between consecutive pulses on one lane.
    always_comb begin
        inc_d = up_evt & ~dn_evt & ~inc_q;
        dec_d = dn_evt & ~up_evt & ~dec_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
        end else begin
            inc_q <= inc_d;
            dec_q <= dec_d;
        end
    end

    assign increase_duty_sync = inc_q;
    assign decrease_duty_sync = dec_q;

endmodule
